// File: rtl/uart_word_loader.sv
// uart_word_loader
//   Feeds the CPU "in" instruction. An 8N1 UART receiver deserialises bytes
//   from the host into a small byte FIFO. On an "in" request the word FSM pulls
//   four bytes, MSB first, assembles a 32-bit word and hands it to the register
//   file as a single-cycle write.
//
// Handshake: in_req is a one-cycle pulse and is accepted only in W_IDLE. stall
//   is high from the cycle after acceptance until the word is complete. The
//   write is a one-cycle strobe on UART_write_enable, with rw/write_data valid
//   in that cycle. distinct toggles on each completed write.
//
// Ports
//   CLK               core clock
//   reset_n           asynchronous active-low reset
//   rxd               UART receive line (asynchronous, idle high)
//   in_req            one-cycle "in" request from decode
//   in_rd[4:0]        destination register, latched on an accepted request
//   stall             pipeline hold while a requested word is incomplete
//   UART_write_enable one-cycle register-file write strobe
//   rw[4:0]           destination register of the last write
//   write_data[31:0]  last assembled word
//   distinct          toggles once per completed write
//   frame_err         sticky: bad stop bit or FIFO overflow
module uart_word_loader #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        CLK,
    input  logic        reset_n,
    input  logic        rxd,
    input  logic        in_req,
    input  logic [4:0]  in_rd,
    output logic        stall,
    output logic        UART_write_enable,
    output logic [4:0]  rw,
    output logic [31:0] write_data,
    output logic        distinct,
    output logic        frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] TICK_ONE  = CW'(1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);

    // ---------------- input synchroniser ----------------
    logic rxd_s1_q, rxd_s2_q;
    logic rx_bit;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            rxd_s1_q <= 1'b1;
            rxd_s2_q <= 1'b1;
        end else begin
            rxd_s1_q <= rxd;
            rxd_s2_q <= rxd_s1_q;
        end
    end

    assign rx_bit = rxd_s2_q;

    // ---------------- RX FSM ----------------
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK   // bad stop bit seen; wait for the line to return high
    } rx_state_t;

    rx_state_t   rx_state_q, rx_state_d;
    logic [CW-1:0] tick_q, tick_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        rx_push;
    logic        rx_bad_stop;

    always_comb begin
        rx_state_d  = rx_state_q;
        tick_d      = tick_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_push     = 1'b0;
        rx_bad_stop = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_bit) begin
                    rx_state_d = RX_START;
                    tick_d     = '0;
                    bit_idx_d  = '0;
                end
            end
            RX_START: begin
                // Re-check at mid start bit so a short low glitch is ignored.
                if (tick_q == HALF_LAST) begin
                    tick_d     = '0;
                    rx_state_d = rx_bit ? RX_IDLE : RX_DATA;
                end else begin
                    tick_d = tick_q + TICK_ONE;
                end
            end
            RX_DATA: begin
                if (tick_q == BIT_LAST) begin
                    tick_d    = '0;
                    shift_d   = {rx_bit, shift_q[7:1]};   // LSB arrives first
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
                end else begin
                    tick_d = tick_q + TICK_ONE;
                end
            end
            RX_STOP: begin
                if (tick_q == BIT_LAST) begin
                    tick_d = '0;
                    if (rx_bit) begin
                        rx_push    = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_bad_stop = 1'b1;
                        rx_state_d  = RX_BREAK;
                    end
                end else begin
                    tick_d = tick_q + TICK_ONE;
                end
            end
            RX_BREAK: begin
                if (rx_bit) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ---------------- byte FIFO ----------------
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic        fifo_empty, fifo_full, fifo_pop, push_ok, overflow;
    logic [7:0]  fifo_rdata;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // A pop in the same cycle frees the slot, so push into a full FIFO is safe then.
    assign push_ok    = rx_push && (!fifo_full || fifo_pop);
    assign overflow   = rx_push && fifo_full && !fifo_pop;
    assign fifo_rdata = mem_q[rd_ptr_q[AW-1:0]];
    assign wr_ptr_d   = push_ok  ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    assign rd_ptr_d   = fifo_pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    always_ff @(posedge CLK) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
    end

    // ---------------- word FSM ----------------
    typedef enum logic [1:0] {
        W_IDLE,
        W_COLLECT,
        W_WRITE
    } w_state_t;

    w_state_t    w_state_q, w_state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [4:0]  rd_q, rd_d;
    logic [23:0] word_q, word_d;
    logic [31:0] write_data_q, write_data_d;
    logic [4:0]  rw_q, rw_d;
    logic        distinct_q, distinct_d;
    logic        frame_err_q, frame_err_d;

    always_comb begin
        w_state_d    = w_state_q;
        byte_cnt_d   = byte_cnt_q;
        rd_d         = rd_q;
        word_d       = word_q;
        write_data_d = write_data_q;
        rw_d         = rw_q;
        distinct_d   = distinct_q;
        fifo_pop     = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (in_req) begin
                    rd_d       = in_rd;
                    byte_cnt_d = '0;
                    w_state_d  = W_COLLECT;
                end
            end
            W_COLLECT: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    word_d     = {word_q[15:0], fifo_rdata};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        // Outputs update only here so they hold between writes.
                        write_data_d = {word_q, fifo_rdata};
                        rw_d         = rd_q;
                        distinct_d   = ~distinct_q;
                        w_state_d    = W_WRITE;
                    end
                end
            end
            W_WRITE: w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    assign frame_err_d = frame_err_q | rx_bad_stop | overflow;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            rx_state_q   <= RX_IDLE;
            tick_q       <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            w_state_q    <= W_IDLE;
            byte_cnt_q   <= '0;
            rd_q         <= '0;
            word_q       <= '0;
            write_data_q <= '0;
            rw_q         <= '0;
            distinct_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            tick_q       <= tick_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            w_state_q    <= w_state_d;
            byte_cnt_q   <= byte_cnt_d;
            rd_q         <= rd_d;
            word_q       <= word_d;
            write_data_q <= write_data_d;
            rw_q         <= rw_d;
            distinct_q   <= distinct_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign stall             = (w_state_q == W_COLLECT);
    assign UART_write_enable = (w_state_q == W_WRITE);
    assign rw                = rw_q;
    assign write_data        = write_data_q;
    assign distinct          = distinct_q;
    assign frame_err         = frame_err_q;

endmodule

// File: tb/tb_uart_word_loader.sv
// Bench for uart_word_loader: directed UART frames and "in" requests; a
// negedge monitor pops expected {rw, write_data, distinct} on every strobe.
module tb_uart_word_loader;

    localparam int CPB = 4;
    localparam int W   = 38;

    logic        CLK = 1'b0;
    logic        reset_n = 1'b0;
    logic        rxd = 1'b1;
    logic        in_req = 1'b0;
    logic [4:0]  in_rd = '0;
    logic        stall, UART_write_enable, distinct, frame_err;
    logic [4:0]  rw;
    logic [31:0] write_data;

    int n_tests = 0;
    int n_fail = 0;
    int n_writes = 0;
    logic exp_distinct = 1'b0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_exp;

    uart_word_loader #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
        .CLK(CLK), .reset_n(reset_n), .rxd(rxd), .in_req(in_req), .in_rd(in_rd),
        .stall(stall), .UART_write_enable(UART_write_enable), .rw(rw),
        .write_data(write_data), .distinct(distinct), .frame_err(frame_err)
    );

    // ---------------- clock / watchdog ----------------
    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge CLK) begin
        if (reset_n && UART_write_enable) begin
            n_writes++;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: rw=%0d data=%h distinct=%0b, no write expected",
                         rw, write_data, distinct);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({rw, write_data, distinct} !== mon_exp) begin
                    n_fail++;
                    $display("FAIL write: got rw=%0d data=%h distinct=%0b, expected rw=%0d data=%h distinct=%0b",
                             rw, write_data, distinct, mon_exp[37:33], mon_exp[32:1], mon_exp[0]);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            cycles(CPB);
        end
        rxd = stop_bit;
        cycles(CPB);
        rxd = 1'b1;
        cycles(2 * CPB);
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24], 1'b1);
        send_byte(w[23:16], 1'b1);
        send_byte(w[15:8], 1'b1);
        send_byte(w[7:0], 1'b1);
    endtask

    task automatic expect_write(input logic [4:0] rd, input logic [31:0] w);
        exp_distinct = ~exp_distinct;
        exp_q.push_back({rd, w, exp_distinct});
    endtask

    task automatic issue_req(input logic [4:0] rd, input logic [31:0] w);
        expect_write(rd, w);
        in_rd  = rd;
        in_req = 1'b1;
        cycles(1);
        in_req = 1'b0;
    endtask

    // Request with cycle-exact stall / strobe timing checks (bytes already buffered).
    task automatic issue_req_timed(input logic [4:0] rd, input logic [31:0] w);
        expect_write(rd, w);
        in_rd  = rd;
        in_req = 1'b1;
        @(negedge CLK);
        check("stall_not_in_req_cycle", stall, 1'b0);
        @(posedge CLK);
        #1;
        in_req = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge CLK);
            check($sformatf("stall_T+%0d", i), stall, 1'b1);
            check($sformatf("no_we_T+%0d", i), UART_write_enable, 1'b0);
        end
        @(negedge CLK);
        check("we_at_T+5", UART_write_enable, 1'b1);
        check("stall_low_at_T+5", stall, 1'b0);
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_writes(input int target);
        int budget;
        budget = 2000;
        while (n_writes < target && budget > 0) begin
            @(negedge CLK);
            budget--;
        end
        if (n_writes < target) begin
            n_tests++;
            n_fail++;
            $display("FAIL write_timeout: got %0d writes expected %0d", n_writes, target);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        exp_distinct = 1'b0;
        check("reset_outputs_zero",
              {stall, UART_write_enable, rw, write_data, distinct, frame_err}, '0);
        cycles(3);
        reset_n = 1'b1;
        cycles(2);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #1;
        check("initial_reset_outputs_zero",
              {stall, UART_write_enable, rw, write_data, distinct, frame_err}, '0);
        cycles(3);
        reset_n = 1'b1;
        cycles(2);

        // 1: buffered word, exact latency
        send_word(32'h12345678);
        cycles(4);
        issue_req_timed(5'd5, 32'h12345678);
        check("t1_rw_hold", rw, 5'd5);
        check("t1_data_hold", write_data, 32'h12345678);

        // 2: request before data arrives
        issue_req(5'd3, 32'hDEADBEEF);
        check("t2_stall_empty", stall, 1'b1);
        send_byte(8'hDE, 1'b1);
        check("t2_stall_1byte", stall, 1'b1);
        send_byte(8'hAD, 1'b1);
        check("t2_stall_2byte", stall, 1'b1);
        send_byte(8'hBE, 1'b1);
        check("t2_stall_3byte", stall, 1'b1);
        send_byte(8'hEF, 1'b1);
        wait_writes(2);
        check("t2_stall_released", stall, 1'b0);

        // 3: back-to-back words
        send_word(32'h00000001);
        send_word(32'hFFFFFFFF);
        issue_req(5'd1, 32'h00000001);
        wait_writes(3);
        issue_req(5'd2, 32'hFFFFFFFF);
        wait_writes(4);
        check("t3_no_frame_err", frame_err, 1'b0);

        // 4: bad stop bit drops 0xAA, 0x55 kept
        send_byte(8'hAA, 1'b0);
        check("t4_frame_err", frame_err, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        issue_req(5'd7, 32'h55112233);
        wait_writes(5);

        // 5: overflow drops the 9th byte
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            send_byte(8'(i), 1'b1);
        end
        check("t5_overflow_err", frame_err, 1'b1);
        issue_req(5'd4, 32'h01020304);
        wait_writes(6);
        issue_req(5'd6, 32'h05060708);
        wait_writes(7);
        send_word(32'hA0A1A2A3);
        issue_req(5'd8, 32'hA0A1A2A3);
        wait_writes(8);

        // 6: reset mid-word
        issue_req(5'd9, 32'h13572468);
        send_byte(8'h13, 1'b1);
        send_byte(8'h57, 1'b1);
        check("t6_stall_mid_word", stall, 1'b1);
        do_reset();
        check("t6_idle_after_reset", stall, 1'b0);
        send_word(32'hCAFEF00D);
        issue_req(5'd10, 32'hCAFEF00D);
        wait_writes(9);
        check("t6_no_frame_err", frame_err, 1'b0);

        cycles(10);
        check("scoreboard_drained", exp_q.size(), 0);
        check("total_writes", n_writes, 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
